// File: rtl/fft_bin_reader.sv
// Read-side sequencer for the 8-point FFT core: steps sel 0..7, settles, captures and streams each bin.
// Define FFT_BIN_READER_MAG_EN to add out_mag = |re|+|im| captured alongside each bin.
module fft_bin_reader #(
    parameter int DW     = 9,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [2:0]    sel_out,
    input  logic [DW-1:0] bin_re_in,
    input  logic [DW-1:0] bin_im_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
`ifdef FFT_BIN_READER_MAG_EN
    output logic [DW:0]   out_mag,
`endif
    output logic [2:0]    out_idx,
    output logic          out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] re_q, re_d;
    logic [DW-1:0] im_q, im_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            re_q    <= re_d;
            im_q    <= im_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        re_d    = re_q;
        im_d    = im_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The done cycle is already IDLE, but a start there must not be taken.
                if (start && !done_q) begin
                    state_d = S_WAIT;
                    sel_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture = 1'b1;
                    re_d    = bin_re_in;
                    im_d    = bin_im_in;
                    idx_d   = sel_q;
                    last_d  = (sel_q == 3'd7);
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == 3'd7) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        sel_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        sel_d   = idx_q + 3'd1;
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FFT_BIN_READER_MAG_EN
    logic [DW:0] abs_re, abs_im, mag_q, mag_d;

    // One extra bit makes |most negative| exact without saturation.
    always_comb begin
        abs_re = bin_re_in[DW-1] ? (~{1'b1, bin_re_in} + 1'b1) : {1'b0, bin_re_in};
        abs_im = bin_im_in[DW-1] ? (~{1'b1, bin_im_in} + 1'b1) : {1'b0, bin_im_in};
        mag_d  = capture ? (abs_re + abs_im) : mag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign out_mag = mag_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign sel_out   = sel_q;
    assign out_valid = valid_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: doc/fft_bin_reader.md
Name: fft_bin_reader

Overview:
- Read-side sequencer for the 8-point DIT FFT core.
- The FFT core presents one bin at a time, combinationally or registered, selected by a 3-bit `sel`.
- On `start`, this block steps `sel` through bins 0..7 and waits a programmable settle time per bin.
- It captures each bin's real/imag pair and streams it downstream over a valid/ready interface with index and last tagging.

Parameters:
- DW, 9: bin component width (signed two's complement); matches FFT y_real/y_img.
- SETTLE, 2: cycles from a `sel_out` change to capture; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  frame read request; sampled only in IDLE
- busy  out  1  high from accepted start until frame done
- done  out  1  one-cycle pulse after the last bin handshake
- sel_out  out  3  bin select to FFT core `sel`
- bin_re_in  in  DW  FFT y_real
- bin_im_in  in  DW  FFT y_img
- out_valid  out  1  captured bin available
- out_ready  in  1  downstream accepts
- out_re  out  DW  captured real part
- out_im  out  DW  captured imag part
- out_idx  out  3  bin index of the current beat
- out_last  out  1  high with out_valid when out_idx==7

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state IDLE.
  - busy, done, out_valid, out_last = 0.
  - sel_out, out_idx, out_re, out_im = 0.
  - Settle counter = 0.
  - rst has priority over every other input.
- States: IDLE, WAIT, PRESENT.
- IDLE:
  - start=1 at edge T0 -> WAIT, sel_out=0, busy=1, cnt=SETTLE-1.
  - start=0 -> stay.
- WAIT:
  - cnt!=0 -> cnt-1.
  - cnt==0 -> capture bin_re_in/bin_im_in into out_re/out_im, out_idx=sel_out, out_last=(sel_out==7), out_valid=1 -> PRESENT.
  - First capture edge = T0+SETTLE, so out_valid is visible after that edge.
- PRESENT:
  - out_valid held; out_re/out_im/out_idx/out_last stable until handshake.
  - Handshake = out_valid & out_ready at an edge.
  - On handshake with idx<7: out_valid=0, out_last=0, sel_out=idx+1, cnt=SETTLE-1 -> WAIT.
  - On handshake with idx==7: out_valid=0, out_last=0, busy=0, done=1 for exactly one cycle, sel_out=0 -> IDLE.
  - No handshake: hold indefinitely (no timeout).
- Per-bin minimum period is SETTLE+1 cycles; with ready tied high, a frame takes 8*(SETTLE+1) cycles from start to done.
- out_valid never asserts without a preceding settle interval; out_ready is ignored while out_valid=0.
- start during busy (WAIT/PRESENT) is ignored, not queued.
- start in the same cycle that done pulses is ignored; done's cycle is IDLE-entry, and start is accepted from the next cycle.
- sel_out changes only on an accepted start or on a handshake, and wraps 7->0 only at frame end.
- Data pass-through is bit-exact with no sign/width change.
- Reset mid-frame aborts immediately, returns to the reset values, and does not pulse done.

Optional Feature:
- Macro FFT_BIN_READER_MAG_EN.
- Defined:
  - Adds output port out_mag [DW:0], unsigned.
  - out_mag = |re|+|im|, registered at the same capture edge as out_re/out_im and held with them.
  - |x| of the most negative value is 2^(DW-1), exact with no saturation.
  - out_mag resets to 0.
- Undefined: no port, no logic; behaviour otherwise identical.

Test Plan:
- Reset values: assert rst 3 cycles mid-idle -> all outputs 0. Apply start=1 together with rst -> still IDLE, busy=0.
- Full frame, SETTLE=2, out_ready=1:
  - FFT model drives re=3*sel, im=-sel.
  - Expect 8 beats, out_idx 0..7, (out_re,out_im)=(0,0),(3,-1)..(21,-7).
  - out_last only on idx 7; done one cycle; first valid 2 cycles after the start edge; done 24 cycles after the start edge.
- Backpressure: out_ready=0 for 5 cycles at idx 3 -> out_valid, out_re=9, out_im=-3 held stable, sel_out=3 unchanged; release -> idx 4 follows after SETTLE cycles.
- start pulsed during bin 5 wait and in the done cycle -> ignored; exactly one done per frame; a new start one cycle later begins a new frame at idx 0.
- rst at idx 4 while PRESENT -> next cycle out_valid=0, busy=0, sel_out=0, no done pulse; a following start reads a full 8-bin frame.
- With FFT_BIN_READER_MAG_EN: re=-256, im=255 -> out_mag=511; re=-3, im=0 -> out_mag=3.
